// File: rtl/seq_mult_4x4.sv
// rtl/seq_mult_4x4.sv - sequential 4x4 unsigned shift-and-add multiplier
// Drives an external 4-bit ripple adder through fa_* and retires one partial product per clock.
module seq_mult_4x4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mcand,
  input  logic [3:0] mplier,
  output logic [7:0] product,
  output logic       busy,
  output logic       done,
  output logic [3:0] fa_a,
  output logic [3:0] fa_b,
  output logic       fa_cin,
  input  logic [3:0] fa_s,
  input  logic       fa_cout
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [3:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Adder inputs come only from registers, so fa_s never feeds back combinationally.
  assign fa_a   = acc_q;
  assign fa_b   = q_q[0] ? m_q : 4'b0000;
  assign fa_cin = 1'b0;

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = mcand;
          q_d     = mplier;
          acc_d   = 4'b0000;
          cnt_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // The adder carry becomes the new ACC msb so no product bit is lost.
        acc_d = {fa_cout, fa_s[3:1]};
        q_d   = {fa_s[0], q_q[3:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          product_d = {acc_d, q_d};
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= 4'b0000;
      q_q       <= 4'b0000;
      acc_q     <= 4'b0000;
      cnt_q     <= 3'd0;
      product_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_mult_4x4.sv
// tb/tb_seq_mult_4x4.sv - self-checking bench for seq_mult_4x4
// Models the external ripple adder and scoreboards products against a table of constants.
module tb_seq_mult_4x4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] mcand;
  logic [3:0] mplier;
  logic [7:0] product;
  logic       busy;
  logic       done;
  logic [3:0] fa_a;
  logic [3:0] fa_b;
  logic       fa_cin;
  logic [3:0] fa_s;
  logic       fa_cout;
  logic [4:0] fa_sum;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_prod = 8'h00;
  logic       prev_done = 1'b0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;
  vec_t vecs[10];

  seq_mult_4x4 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mcand  (mcand),
    .mplier (mplier),
    .product(product),
    .busy   (busy),
    .done   (done),
    .fa_a   (fa_a),
    .fa_b   (fa_b),
    .fa_cin (fa_cin),
    .fa_s   (fa_s),
    .fa_cout(fa_cout)
  );

  assign fa_sum  = {1'b0, fa_a} + {1'b0, fa_b} + {4'b0000, fa_cin};
  assign fa_s    = fa_sum[3:0];
  assign fa_cout = fa_sum[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      check("done_not_consecutive", prev_done, 1'b0);
      check("busy_low_at_done", busy, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        last_prod = exp_q.pop_front();
        check("product", product, last_prod);
      end
    end
    prev_done = done;
  end

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p);
    int lat;
    int busy_n;
    logic got;
    @(negedge clk);
    mcand = a; mplier = b; start = 1'b1;
    exp_q.push_back(p);
    @(negedge clk);
    start = 1'b0;
    lat = -1; busy_n = 0; got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (done) begin
        got = 1'b1;
        lat = i;
      end else begin
        if (busy) busy_n++;
        if (i < 4) check("fa_b_step", fa_b, b[i] ? a : 4'h0);
        check("product_hold", product, last_prod);
        @(negedge clk);
      end
    end
    check("done_seen", got, 1'b1);
    check("latency", lat, 4);
    check("busy_cycles", busy_n, 4);
  endtask

  initial begin
    int idx_n;
    int done_at[2];
    logic got;
    int lat;

    vecs[0] = '{4'h0, 4'h0, 8'h00};
    vecs[1] = '{4'hF, 4'hF, 8'hE1};
    vecs[2] = '{4'd3, 4'd5, 8'h0F};
    vecs[3] = '{4'd14, 4'd1, 8'h0E};
    vecs[4] = '{4'hF, 4'h5, 8'h4B};
    vecs[5] = '{4'h8, 4'h8, 8'h40};
    vecs[6] = '{4'h0, 4'hF, 8'h00};
    vecs[7] = '{4'hF, 4'h1, 8'h0F};
    vecs[8] = '{4'hA, 4'hB, 8'h6E};
    vecs[9] = '{4'h7, 4'hD, 8'h5B};

    rst_n = 1'b0; start = 1'b0; mcand = 4'h0; mplier = 4'h0;
    #2;
    check("rst_product", product, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fa_a", fa_a, 4'h0);
    check("rst_fa_b", fa_b, 4'h0);
    check("rst_fa_cin", fa_cin, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) run_op(vecs[v].a, vecs[v].b, vecs[v].p);

    // Start held high: second operands captured in DONE, one cycle after the first done.
    @(negedge clk);
    mcand = 4'd2; mplier = 4'd7; start = 1'b1;
    exp_q.push_back(8'h0E);
    exp_q.push_back(8'h51);
    idx_n = 0; done_at[0] = -1; done_at[1] = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin mcand = 4'd9; mplier = 4'd9; end
      if (done && idx_n < 2) begin done_at[idx_n] = i; idx_n++; end
      if (i == 9) start = 1'b0;
    end
    check("b2b_done_count", idx_n, 2);
    check("b2b_first_done", done_at[0], 4);
    check("b2b_second_done", done_at[1], 9);

    // A start pulse during CALC must not disturb the captured operands.
    @(negedge clk);
    @(negedge clk);
    mcand = 4'd3; mplier = 4'd5; start = 1'b1;
    exp_q.push_back(8'h0F);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mcand = 4'hF; mplier = 4'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", busy, 1'b1);
    got = 1'b0; lat = -1;
    for (int i = 0; i < 10 && !got; i++) begin
      if (done) begin got = 1'b1; lat = i; end
      else @(negedge clk);
    end
    check("ign_done_lat", lat, 2);
    @(negedge clk);
    check("ign_no_restart_busy", busy, 1'b0);
    check("ign_no_restart_done", done, 1'b0);

    // Asynchronous reset in the middle of CALC aborts without a done pulse.
    @(negedge clk);
    mcand = 4'd4; mplier = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_product", product, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_fa_a", fa_a, 4'h0);
    check("abort_fa_b", fa_b, 4'h0);
    last_prod = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_done_after", done, 1'b0);
    end
    run_op(4'd6, 4'd6, 8'h24);

    @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
